// File: rtl/uart_program_loader_pkg.sv
// Shared definitions for the UART program loader: sync byte and the state encodings
// used by the frame FSM and the byte receiver.
package uart_program_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {SYNC, LEN0, LEN1, DATA, CSUM, DONE, ERR} load_state_t;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling, one-cycle
// byte_valid on a good stop bit and one-cycle frame_err on a low stop bit.
module uart_rx_byte
    import uart_program_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic            rx_s1;
    logic            rx_s2;
    logic            rx_prev;
    rx_state_t       state;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_prev    <= 1'b1;
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            data       <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_s1      <= rx;
            rx_s2      <= rx_s1;
            rx_prev    <= rx_s2;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        state <= RX_START;
                        cnt   <= '0;
                    end
                end
                RX_START: begin
                    // A start bit that is high again at mid-bit was a glitch.
                    if (cnt == HALF_M1) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s2 ? RX_IDLE : RX_BITS;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_BITS: begin
                    if (cnt == FULL_M1) begin
                        cnt     <= '0;
                        shreg   <= {rx_s2, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= RX_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (rx_s2) begin
                            data       <= shreg;
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: parses a sync/length/words/checksum frame from UART into instruction
// memory and releases the core from reset only after a verified image.
module uart_program_loader
    import uart_program_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 10,
    parameter int IMEM_WORDS   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              load_done,
    output logic              load_err
);

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_frame_err;

    load_state_t state;
    logic [15:0] len;
    logic [15:0] word_cnt;
    logic [1:0]  byte_idx;
    logic [31:0] word_asm;
    logic [7:0]  csum;
    logic [15:0] len_next;

    assign len_next = {rx_data, len[7:0]};

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (rx_data),
        .byte_valid(rx_valid),
        .frame_err (rx_frame_err)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= SYNC;
            len        <= '0;
            word_cnt   <= '0;
            byte_idx   <= '0;
            word_asm   <= '0;
            csum       <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_rst_n <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            // Address advances the cycle after each write so it is stable during the strobe.
            if (imem_we) imem_addr <= imem_addr + 1'b1;

            if (rx_frame_err && state != DONE && state != ERR) begin
                state    <= ERR;
                load_err <= 1'b1;
            end else if (rx_valid) begin
                case (state)
                    SYNC: begin
                        if (rx_data == SYNC_BYTE) begin
                            state <= LEN0;
                            csum  <= '0;
                        end
                    end
                    LEN0: begin
                        len[7:0] <= rx_data;
                        csum     <= csum ^ rx_data;
                        state    <= LEN1;
                    end
                    LEN1: begin
                        len[15:8] <= rx_data;
                        csum      <= csum ^ rx_data;
                        word_cnt  <= '0;
                        byte_idx  <= '0;
                        if ({16'd0, len_next} > 32'(IMEM_WORDS)) begin
                            state    <= ERR;
                            load_err <= 1'b1;
                        end else if (len_next == 16'd0) begin
                            state <= CSUM;
                        end else begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        csum     <= csum ^ rx_data;
                        word_asm <= {rx_data, word_asm[31:8]};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            imem_wdata <= {rx_data, word_asm[31:8]};
                            imem_we    <= 1'b1;
                            word_cnt   <= word_cnt + 16'd1;
                            if (word_cnt == len - 16'd1) state <= CSUM;
                        end
                    end
                    CSUM: begin
                        if (rx_data == csum) begin
                            state      <= DONE;
                            load_done  <= 1'b1;
                            core_rst_n <= 1'b1;
                        end else begin
                            state    <= ERR;
                            load_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
